// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronises the raw line pair, deserialises
// 11-bit device-to-host frames and tracks F0/E0 prefixes so that `data`
// holds the make code of the key currently down (0x00 when none).
module ps2_scan_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       key_down,
   output logic       code_stb,
   output logic       frame_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // True when the eight data bits plus the parity bit hold an odd count of ones
   function automatic logic odd_parity(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction

   logic          clk_s1_r, clk_s2_r, clk_s3_r;
   logic          dat_s1_r, dat_s2_r;
   logic          fall_s;
   logic          timeout_s;
   state_t        state_r, state_nxt_s;
   logic [7:0]    sr_r, sr_nxt_s;
   logic [2:0]    bit_cnt_r, bit_cnt_nxt_s;
   logic          par_r, par_nxt_s;
   logic [CW-1:0] to_cnt_r, to_cnt_nxt_s;
   logic          good_s, err_s;
   logic          brk_r, brk_nxt_s;
   logic          ext_r, ext_nxt_s;
   logic [7:0]    data_r, data_nxt_s;
   logic          key_down_r, key_down_nxt_s;
   logic          code_stb_r, frame_err_r;

   assign fall_s    = clk_s3_r & ~clk_s2_r;
   assign timeout_s = (to_cnt_r == CW'(TIMEOUT_CYCLES - 1));

   // Bring the asynchronous keyboard pins into the clk domain (idle high)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_r <= 1'b1;
         clk_s2_r <= 1'b1;
         clk_s3_r <= 1'b1;
         dat_s1_r <= 1'b1;
         dat_s2_r <= 1'b1;
      end else begin
         clk_s1_r <= ps2_clk;
         clk_s2_r <= clk_s1_r;
         clk_s3_r <= clk_s2_r;
         dat_s1_r <= ps2_data;
         dat_s2_r <= dat_s1_r;
      end
   end

   // Frame state machine and deserialiser registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         sr_r      <= 8'h00;
         bit_cnt_r <= 3'd0;
         par_r     <= 1'b0;
         to_cnt_r  <= '0;
      end else begin
         state_r   <= state_nxt_s;
         sr_r      <= sr_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         par_r     <= par_nxt_s;
         to_cnt_r  <= to_cnt_nxt_s;
      end
   end

   // Next-state logic: a ps2_clk fall always beats a simultaneous timeout
   always_comb begin
      state_nxt_s   = state_r;
      sr_nxt_s      = sr_r;
      bit_cnt_nxt_s = bit_cnt_r;
      par_nxt_s     = par_r;
      to_cnt_nxt_s  = '0;
      good_s        = 1'b0;
      err_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s && !dat_s2_r) begin
               state_nxt_s   = ST_DATA;
               bit_cnt_nxt_s = 3'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (fall_s) begin
               sr_nxt_s      = {dat_s2_r, sr_r[7:1]};
               bit_cnt_nxt_s = bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
                  state_nxt_s = ST_PARITY;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else if (timeout_s) begin
               state_nxt_s = ST_IDLE;
               err_s       = 1'b1;
            end else begin
               to_cnt_nxt_s = to_cnt_r + CW'(1);
            end
         end
         ST_PARITY: begin
            if (fall_s) begin
               par_nxt_s   = dat_s2_r;
               state_nxt_s = ST_STOP;
            end else if (timeout_s) begin
               state_nxt_s = ST_IDLE;
               err_s       = 1'b1;
            end else begin
               to_cnt_nxt_s = to_cnt_r + CW'(1);
            end
         end
         ST_STOP: begin
            if (fall_s) begin
               state_nxt_s = ST_IDLE;
               if (dat_s2_r && odd_parity(sr_r, par_r)) begin
                  good_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
            end else if (timeout_s) begin
               state_nxt_s = ST_IDLE;
               err_s       = 1'b1;
            end else begin
               to_cnt_nxt_s = to_cnt_r + CW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Make/break tracking on each good byte; discarded frames leave prefixes alone
   always_comb begin
      brk_nxt_s      = brk_r;
      ext_nxt_s      = ext_r;
      data_nxt_s     = data_r;
      key_down_nxt_s = key_down_r;
      if (good_s) begin
         if (sr_r == 8'hF0) begin
            brk_nxt_s = 1'b1;
         end else if (sr_r == 8'hE0) begin
            ext_nxt_s = 1'b1;
         end else if (brk_r) begin
            if (sr_r == data_r) begin
               data_nxt_s     = 8'h00;
               key_down_nxt_s = 1'b0;
            end else begin
               data_nxt_s = data_r;
            end
            brk_nxt_s = 1'b0;
            ext_nxt_s = 1'b0;
         end else begin
            data_nxt_s     = sr_r;
            key_down_nxt_s = 1'b1;
            ext_nxt_s      = 1'b0;
         end
      end else begin
         data_nxt_s = data_r;
      end
   end

   // Registered key state and one-cycle status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         brk_r       <= 1'b0;
         ext_r       <= 1'b0;
         data_r      <= 8'h00;
         key_down_r  <= 1'b0;
         code_stb_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         brk_r       <= brk_nxt_s;
         ext_r       <= ext_nxt_s;
         data_r      <= data_nxt_s;
         key_down_r  <= key_down_nxt_s;
         code_stb_r  <= good_s;
         frame_err_r <= err_s;
      end
   end

   assign data      = data_r;
   assign key_down  = key_down_r;
   assign code_stb  = code_stb_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: drives PS/2 frames bit by bit and
// checks held scan code, key_down and the strobe/error pulse counts.
module tb_ps2_scan_decoder;

   localparam int TO = 1000;
   localparam int H  = 8;

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data;
   logic       key_down;
   logic       code_stb;
   logic       frame_err;

   int checks_cnt = 0;
   int fail_cnt   = 0;
   int stb_cnt    = 0;
   int err_cnt    = 0;
   int both_cnt   = 0;
   int s0, e0;

   ps2_scan_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .data      (data),
      .key_down  (key_down),
      .code_stb  (code_stb),
      .frame_err (frame_err)
   );

   // 100 MHz system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count pulse cycles away from the active edge
   always @(negedge clk) begin
      if (code_stb) stb_cnt = stb_cnt + 1;
      if (frame_err) err_cnt = err_cnt + 1;
      if (code_stb && frame_err) both_cnt = both_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt = checks_cnt + 1;
      if (obs !== exp) begin
         fail_cnt = fail_cnt + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(posedge clk); #1 ps2_data = b;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b1;
   endtask

   // One full frame; chk verifies edge-exact output timing on the stop bit
   task automatic send_frame(input logic [7:0] b, input logic flip_par,
                             input logic stop, input logic chk);
      logic [10:0] fr;
      fr = {stop, (~(^b)) ^ flip_par, b, 1'b0};
      for (int i = 0; i < 10; i++) send_bit(fr[i]);
      if (chk) begin
         @(posedge clk); #1 ps2_data = fr[10];
         repeat (H) @(posedge clk);
         #1 ps2_clk = 1'b0;
         @(posedge clk);            // edge k
         @(posedge clk);            // edge k+1
         #1 check_eq("stb_before_k2", {31'd0, code_stb}, 32'd0);
         @(posedge clk);            // edge k+2
         #1 check_eq("stb_at_k2", {31'd0, code_stb}, 32'd1);
         check_eq("data_at_k2", {24'd0, data}, {24'd0, b});
         check_eq("kd_at_k2", {31'd0, key_down}, 32'd1);
         repeat (H - 3) @(posedge clk);
         #1 ps2_clk = 1'b1;
      end else begin
         send_bit(fr[10]);
      end
      repeat (H) @(posedge clk);
      #1 ps2_data = 1'b1;
   endtask

   task automatic frame_expect(input string tag, input logic [7:0] b, input logic flip_par,
                               input logic stop, input logic [7:0] exp_data, input logic exp_kd,
                               input int exp_stb, input int exp_err);
      s0 = stb_cnt;
      e0 = err_cnt;
      send_frame(b, flip_par, stop, 1'b0);
      check_eq({tag, "_data"}, {24'd0, data}, {24'd0, exp_data});
      check_eq({tag, "_kd"}, {31'd0, key_down}, {31'd0, exp_kd});
      check_eq({tag, "_stb"}, stb_cnt - s0, exp_stb);
      check_eq({tag, "_err"}, err_cnt - e0, exp_err);
   endtask

   initial begin
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("rst_data", {24'd0, data}, 32'd0);
      check_eq("rst_kd", {31'd0, key_down}, 32'd0);
      check_eq("rst_stb", {31'd0, code_stb}, 32'd0);
      check_eq("rst_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);

      // Make 0x1C with exact output timing
      s0 = stb_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
      check_eq("t1_stb_cnt", stb_cnt - s0, 32'd1);

      // Break F0 1C
      frame_expect("t2_f0", 8'hF0, 1'b0, 1'b1, 8'h1C, 1'b1, 1, 0);
      frame_expect("t2_brk", 8'h1C, 1'b0, 1'b1, 8'h00, 1'b0, 1, 0);

      // Last key wins; release of a non-held key is ignored
      frame_expect("t3_mk1c", 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1, 0);
      frame_expect("t3_rep", 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1, 0);
      frame_expect("t3_mk1b", 8'h1B, 1'b0, 1'b1, 8'h1B, 1'b1, 1, 0);
      frame_expect("t3_f0a", 8'hF0, 1'b0, 1'b1, 8'h1B, 1'b1, 1, 0);
      frame_expect("t3_brk1c", 8'h1C, 1'b0, 1'b1, 8'h1B, 1'b1, 1, 0);
      frame_expect("t3_f0b", 8'hF0, 1'b0, 1'b1, 8'h1B, 1'b1, 1, 0);
      frame_expect("t3_brk1b", 8'h1B, 1'b0, 1'b1, 8'h00, 1'b0, 1, 0);

      // Bad parity / bad stop discard; brk survives a discarded frame
      frame_expect("t4_mk2c", 8'h2C, 1'b0, 1'b1, 8'h2C, 1'b1, 1, 0);
      frame_expect("t4_par", 8'h1C, 1'b1, 1'b1, 8'h2C, 1'b1, 0, 1);
      frame_expect("t4_stop", 8'h1C, 1'b0, 1'b0, 8'h2C, 1'b1, 0, 1);
      frame_expect("t4_f0", 8'hF0, 1'b0, 1'b1, 8'h2C, 1'b1, 1, 0);
      frame_expect("t4_bad", 8'h2C, 1'b1, 1'b1, 8'h2C, 1'b1, 0, 1);
      frame_expect("t4_brk2c", 8'h2C, 1'b0, 1'b1, 8'h00, 1'b0, 1, 0);

      // Timeout of a partial frame
      s0 = stb_cnt;
      e0 = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (TO - 30) @(posedge clk);
      #1 check_eq("t5_no_err_early", err_cnt - e0, 32'd0);
      repeat (60) @(posedge clk);
      #1 check_eq("t5_err", err_cnt - e0, 32'd1);
      check_eq("t5_stb", stb_cnt - s0, 32'd0);
      frame_expect("t5_mk1c", 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1, 0);
      frame_expect("t5_e0", 8'hE0, 1'b0, 1'b1, 8'h1C, 1'b1, 1, 0);

      // Asynchronous reset in the middle of bit 5
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      @(posedge clk); #1 ps2_data = 1'b0;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("t6_rst_data", {24'd0, data}, 32'd0);
      check_eq("t6_rst_kd", {31'd0, key_down}, 32'd0);
      repeat (3) @(posedge clk);
      #1 ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      frame_expect("t6_mk2c", 8'h2C, 1'b0, 1'b1, 8'h2C, 1'b1, 1, 0);

      check_eq("stb_err_overlap", both_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
